// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared state type and default sizes for the regbank_v4 register bank
package regbank_pkg;

  // Default geometry: 32 registers of 32 bits
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  // Clear sequencer states: CLEAR walks the array zeroing one entry per cycle
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_clr_seq.sv
// rtl/regbank_clr_seq.sv - reset/clear sequencer that zeroes the register array one entry per cycle
module regbank_clr_seq
  import regbank_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset lands in CLEAR so the array is scrubbed after power-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state, pointer advance and array-zeroing strobe
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we   = 1'b0;
    busy     = 1'b0;
    clr_addr = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        if (clear) begin
          // A new clear request restarts the walk from entry 0
          ptr_d = '0;
        end else if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/regbank_v4.sv
// rtl/regbank_v4.sv - 2-read/1-write register bank with bypass, zero register, clear sequencer and pending-write scoreboard
module regbank_v4
  import regbank_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             write,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] rdData1,
  output logic [WIDTH-1:0] rdData2,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_dr,
  output logic             pend1,
  output logic             pend2,
  output logic             busy,
  output logic             wrErr
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_acc;
  logic             rsv_acc;
  logic             byp1;
  logic             byp2;

  regbank_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes and reservations only land while idle and not being cleared; register 0 may be hardwired
  assign wr_acc  = write && !busy && !clear && !(ZERO_REG && (dr == '0));
  assign rsv_acc = rsv && !busy && !clear && !(ZERO_REG && (rsv_dr == '0));
  assign byp1    = BYPASS && wr_acc && (dr == sr1);
  assign byp2    = BYPASS && wr_acc && (dr == sr2);

  // Array write port: the clear sequencer owns it while busy, otherwise accepted writes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (wr_acc) begin
      regs[dr] <= wrData;
    end
  end

  // Scoreboard: a reservation set beats a write clear on the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (clear) begin
      pend_q <= '0;
    end else if (!busy) begin
      if (wr_acc) begin
        pend_q[dr] <= 1'b0;
      end
      if (rsv_acc) begin
        pend_q[rsv_dr] <= 1'b1;
      end
    end
  end

  // Dropped-write flag: one-cycle pulse when a write hits a busy or clearing bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrErr <= 1'b0;
    end else begin
      wrErr <= write && (busy || clear);
    end
  end

  // Read ports and pending flags: zero while busy, bypass beats the array and the zero register
  always_comb begin
    rdData1 = '0;
    rdData2 = '0;
    pend1   = 1'b0;
    pend2   = 1'b0;
    if (!busy) begin
      if (byp1) begin
        rdData1 = wrData;
      end else if (!(ZERO_REG && (sr1 == '0))) begin
        rdData1 = regs[sr1];
      end
      if (byp2) begin
        rdData2 = wrData;
      end else if (!(ZERO_REG && (sr2 == '0))) begin
        rdData2 = regs[sr2];
      end
      pend1 = pend_q[sr1] && !byp1;
      pend2 = pend_q[sr2] && !byp2;
    end
  end

endmodule

// File: tb/tb_regbank_v4.sv
// tb/tb_regbank_v4.sv - self-checking bench for regbank_v4 in two configurations driven by shared stimulus
module tb_regbank_v4;

  logic        clk = 1'b0;
  logic        rst_n, clear, write, rsv;
  logic [4:0]  dr, sr1, sr2, rsv_dr;
  logic [31:0] wrData;

  logic [31:0] rd1_a, rd2_a;
  logic        p1_a, p2_a, busy_a, err_a;
  logic [15:0] rd1_b, rd2_b;
  logic        p1_b, p2_b, busy_b, err_b;

  int checks   = 0;
  int failures = 0;

  // Config 0: 32x32, zero reg, bypass.  Config 1: 8x16, no zero reg, no bypass.
  int          dep [2];
  bit          zr  [2];
  bit          bp  [2];
  logic [31:0] msk [2];

  // Reference model: whole array is conceptually zeroed when a clear starts, busy counts down
  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];
  int          m_left [2];
  bit          m_err  [2];

  logic [31:0] obs_rd1  [2];
  logic        obs_p2   [2];
  logic        obs_busy [2];
  logic        obs_err  [2];

  typedef struct {
    logic        wr;
    logic [4:0]  d;
    logic [31:0] wd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        rv;
    logic [4:0]  rdr;
    logic [31:0] a_rd1;
    logic        a_p2;
    logic        a_err;
    logic [15:0] b_rd1;
    logic        b_p2;
  } vec_t;

  vec_t vt [12];

  always #5 clk = ~clk;

  regbank_v4 #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .dr(dr), .wrData(wrData),
    .sr1(sr1), .sr2(sr2), .rdData1(rd1_a), .rdData2(rd2_a), .rsv(rsv), .rsv_dr(rsv_dr),
    .pend1(p1_a), .pend2(p2_a), .busy(busy_a), .wrErr(err_a)
  );

  regbank_v4 #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .dr(dr[2:0]), .wrData(wrData[15:0]),
    .sr1(sr1[2:0]), .sr2(sr2[2:0]), .rdData1(rd1_b), .rdData2(rd2_b), .rsv(rsv), .rsv_dr(rsv_dr[2:0]),
    .pend1(p1_b), .pend2(p2_b), .busy(busy_b), .wrErr(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void m_port(input int c, input int s, input bit bsy, input bit acc, input int adr,
                                 output logic [31:0] rd, output bit p);
    rd = '0;
    p  = 1'b0;
    if (!bsy) begin
      if (bp[c] && acc && adr == s) rd = wrData & msk[c];
      else if (!(zr[c] && s == 0))  rd = m_regs[c][s];
      p = m_pend[c][s] && !(bp[c] && acc && adr == s);
    end
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_left[c] = dep[c];
      m_err[c]  = 1'b0;
      for (int r = 0; r < 32; r++) begin
        m_regs[c][r] = '0;
        m_pend[c][r] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 2; c++) begin
      bit          bsy, acc, ep1, ep2;
      int          adr;
      logic [31:0] er1, er2, ar1, ar2;
      logic        ap1, ap2, ab, ae;
      bsy = m_left[c] > 0;
      adr = int'(dr) % dep[c];
      acc = write && !bsy && !clear && !(zr[c] && adr == 0);
      m_port(c, int'(sr1) % dep[c], bsy, acc, adr, er1, ep1);
      m_port(c, int'(sr2) % dep[c], bsy, acc, adr, er2, ep2);
      ar1 = (c == 0) ? rd1_a : {16'h0, rd1_b};
      ar2 = (c == 0) ? rd2_a : {16'h0, rd2_b};
      ap1 = (c == 0) ? p1_a : p1_b;
      ap2 = (c == 0) ? p2_a : p2_b;
      ab  = (c == 0) ? busy_a : busy_b;
      ae  = (c == 0) ? err_a : err_b;
      chk($sformatf("%s cfg%0d busy", tag, c), 32'(ab), 32'(bsy));
      chk($sformatf("%s cfg%0d rdData1", tag, c), ar1, er1);
      chk($sformatf("%s cfg%0d rdData2", tag, c), ar2, er2);
      chk($sformatf("%s cfg%0d pend1", tag, c), 32'(ap1), 32'(ep1));
      chk($sformatf("%s cfg%0d pend2", tag, c), 32'(ap2), 32'(ep2));
      chk($sformatf("%s cfg%0d wrErr", tag, c), 32'(ae), 32'(m_err[c]));
      obs_rd1[c]  = ar1;
      obs_p2[c]   = ap2;
      obs_busy[c] = ab;
      obs_err[c]  = ae;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      bit bsy, acc;
      int adr, ra;
      bsy = m_left[c] > 0;
      adr = int'(dr) % dep[c];
      ra  = int'(rsv_dr) % dep[c];
      acc = write && !bsy && !clear && !(zr[c] && adr == 0);
      if (clear) begin
        m_left[c] = dep[c];
        for (int r = 0; r < 32; r++) begin
          m_regs[c][r] = '0;
          m_pend[c][r] = 1'b0;
        end
      end else if (bsy) begin
        m_left[c]--;
      end else begin
        if (acc) begin
          m_regs[c][adr] = wrData & msk[c];
          m_pend[c][adr] = 1'b0;
        end
        if (rsv && !(zr[c] && ra == 0)) m_pend[c][ra] = 1'b1;
      end
      m_err[c] = write && (bsy || clear);
    end
  endtask

  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; write = 1'b0; rsv = 1'b0;
    dr = '0; sr1 = '0; sr2 = '0; rsv_dr = '0; wrData = '0;
  endtask

  task automatic count_busy(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      tick("cnt");
      if (obs_busy[0]) na++;
      if (obs_busy[1]) nb++;
      if (!obs_busy[0] && !obs_busy[1]) break;
    end
  endtask

  task automatic read_all(input string tag);
    logic [31:0] acc;
    acc = '0;
    write = 1'b0;
    for (int r = 0; r < 32; r++) begin
      sr1 = 5'(r);
      sr2 = 5'(31 - r);
      tick(tag);
      acc = acc | obs_rd1[0] | obs_rd1[1];
    end
    chk({tag, " all_zero"}, acc, 32'h0);
  endtask

  initial begin
    int na, nb;
    dep[0] = 32; zr[0] = 1'b1; bp[0] = 1'b1; msk[0] = 32'hFFFF_FFFF;
    dep[1] = 8;  zr[1] = 1'b0; bp[1] = 1'b0; msk[1] = 32'h0000_FFFF;

    //          wr    dr     wrData        sr1    sr2    rsv   rsv_dr a_rd1         a_p2  a_err b_rd1     b_p2
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    vt[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 1'b0, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    vt[6]  = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0, 5'd0, 32'h12345678, 1'b0, 1'b0, 16'h0000, 1'b1};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd0, 32'h12345678, 1'b0, 1'b0, 16'h5678, 1'b0};
    vt[8]  = '{1'b1, 5'd7, 32'hAAAA0000, 5'd7, 5'd7, 1'b1, 5'd7, 32'hAAAA0000, 1'b0, 1'b0, 16'h5678, 1'b0};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd0, 32'hAAAA0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vt[10] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 32'h00000000, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vt[11] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 16'hFFFF, 1'b1};

    rst_n = 1'b1;
    idle_inputs();
    #3;

    // Power-up scrub length and contents
    apply_reset();
    count_busy(na, nb);
    chk("reset busy_len cfg0", 32'(na), 32'd32);
    chk("reset busy_len cfg1", 32'(nb), 32'd8);
    read_all("post_rst");

    // Directed vectors: bypass, zero register, scoreboard set/clear priority
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      write = vt[i].wr; dr = vt[i].d; wrData = vt[i].wd;
      sr1 = vt[i].s1; sr2 = vt[i].s2; rsv = vt[i].rv; rsv_dr = vt[i].rdr;
      tick("vec");
      chk($sformatf("vec%0d cfg0 rdData1", i), obs_rd1[0], vt[i].a_rd1);
      chk($sformatf("vec%0d cfg0 pend2", i), 32'(obs_p2[0]), 32'(vt[i].a_p2));
      chk($sformatf("vec%0d cfg0 wrErr", i), 32'(obs_err[0]), 32'(vt[i].a_err));
      chk($sformatf("vec%0d cfg1 rdData1", i), obs_rd1[1], {16'h0, vt[i].b_rd1});
      chk($sformatf("vec%0d cfg1 pend2", i), 32'(obs_p2[1]), 32'(vt[i].b_p2));
    end

    // Clear after loading regs 1-3, with a write dropped on the following cycle
    idle_inputs();
    for (int r = 1; r <= 3; r++) begin
      write = 1'b1; dr = 5'(r); wrData = 32'h1111_1111 * r;
      tick("load");
    end
    idle_inputs();
    clear = 1'b1;
    tick("clr");
    clear = 1'b0; write = 1'b1; dr = 5'd2; wrData = 32'h0000_0055;
    tick("drop");
    idle_inputs();
    tick("drop_err");
    chk("dropped write wrErr cfg0", 32'(obs_err[0]), 32'd1);
    chk("dropped write wrErr cfg1", 32'(obs_err[1]), 32'd1);
    count_busy(na, nb);
    chk("clear busy_len cfg0", 32'(na + 2), 32'd32);
    chk("clear busy_len cfg1", 32'(nb + 2), 32'd8);
    read_all("post_clr");

    // Reset asserted ten cycles into a clear sequence
    clear = 1'b1;
    tick("clr2");
    clear = 1'b0;
    repeat (10) tick("mid");
    chk("busy before abort cfg0", 32'(obs_busy[0]), 32'd1);
    apply_reset();
    count_busy(na, nb);
    chk("abort busy_len cfg0", 32'(na), 32'd32);
    chk("abort busy_len cfg1", 32'(nb), 32'd8);

    // Randomised traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      clear  = ($urandom_range(0, 63) == 0);
      write  = $urandom_range(0, 1) == 1;
      dr     = 5'($urandom);
      wrData = $urandom;
      sr1    = ($urandom_range(0, 2) == 0) ? dr : 5'($urandom);
      sr2    = ($urandom_range(0, 2) == 0) ? dr : 5'($urandom);
      rsv    = ($urandom_range(0, 2) == 0);
      rsv_dr = ($urandom_range(0, 3) == 0) ? dr : 5'($urandom);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
